// File: rtl/regfile_read_port.sv
// Register file read port: two-source reads with write bypass and a
// two-entry (output + skid) response buffer behind a valid/ready channel.
module regfile_read_port #(
  parameter int WIDTH  = 32,
  parameter int NREGS  = 32,
  parameter int ADDR_W = 5
) (
  input  logic                   clk,
  input  logic                   clr_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ADDR_W-1:0]      rs1_addr,
  input  logic [ADDR_W-1:0]      rs2_addr,
  input  logic [NREGS*WIDTH-1:0] regs_flat,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rs1_data,
  output logic [WIDTH-1:0]       rs2_data
);

  logic [WIDTH-1:0] rs1_next;
  logic [WIDTH-1:0] rs2_next;
  logic [WIDTH-1:0] skid_rs1;
  logic [WIDTH-1:0] skid_rs2;
  logic             skid_valid;
  logic             accept;
  logic             out_free;

  // Register 0 reads as zero; a write landing on this edge wins over the
  // bank's current q value because the bank only updates at that edge.
  function automatic logic [WIDTH-1:0] read_src(
    input logic [ADDR_W-1:0]      addr,
    input logic [NREGS*WIDTH-1:0] bank,
    input logic                   we,
    input logic [ADDR_W-1:0]      wa,
    input logic [WIDTH-1:0]       wd
  );
    logic [WIDTH-1:0] value;
    value = '0;
    if (addr != '0) begin
      if (we && (wa == addr)) begin
        value = wd;
      end else begin
        value = bank[addr*WIDTH +: WIDTH];
      end
    end
    return value;
  endfunction

  // Requests are blocked only while the skid entry is occupied, so
  // req_ready depends on registered state alone.
  assign req_ready = !skid_valid;
  assign accept    = req_valid && req_ready;
  assign out_free  = !rsp_valid || rsp_ready;

  // Resolve both source operands in the accept cycle.
  always_comb begin
    rs1_next = read_src(rs1_addr, regs_flat, wr_en, wr_addr, wr_data);
    rs2_next = read_src(rs2_addr, regs_flat, wr_en, wr_addr, wr_data);
  end

  // Output/skid buffer: drain skid first to keep FIFO order, otherwise
  // place a new accept in whichever stage is free.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      rsp_valid  <= 1'b0;
      rs1_data   <= '0;
      rs2_data   <= '0;
      skid_valid <= 1'b0;
      skid_rs1   <= '0;
      skid_rs2   <= '0;
    end else if (skid_valid && rsp_ready) begin
      rs1_data   <= skid_rs1;
      rs2_data   <= skid_rs2;
      rsp_valid  <= 1'b1;
      skid_valid <= 1'b0;
    end else if (accept && out_free) begin
      rs1_data  <= rs1_next;
      rs2_data  <= rs2_next;
      rsp_valid <= 1'b1;
    end else if (accept) begin
      skid_rs1   <= rs1_next;
      skid_rs2   <= rs2_next;
      skid_valid <= 1'b1;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_read_port.sv
// Self-checking bench for regfile_read_port: directed scenarios followed by
// random traffic, compared against a two-deep in-order queue model.
module tb_regfile_read_port;

  logic          clk;
  logic          clr_n;
  logic          req_valid;
  logic          req_ready;
  logic [4:0]    rs1_addr;
  logic [4:0]    rs2_addr;
  logic [1023:0] regs_flat;
  logic          wr_en;
  logic [4:0]    wr_addr;
  logic [31:0]   wr_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rs1_data;
  logic [31:0]   rs2_data;

  logic [31:0] regs [32];
  logic [63:0] exp_q [$];
  int n_checks;
  int n_fail;

  regfile_read_port #(.WIDTH(32), .NREGS(32), .ADDR_W(5)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .regs_flat (regs_flat),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic update_flat();
    for (int i = 0; i < 32; i++) regs_flat[i*32 +: 32] = regs[i];
  endtask

  function automatic logic [31:0] ref_read(input logic [4:0] addr);
    if (addr == 5'd0) return 32'h0;
    if (wr_en && wr_addr == addr) return wr_data;
    return regs[addr];
  endfunction

  task automatic applyStimulus(input logic v, input logic [4:0] a1, input logic [4:0] a2,
                               input logic we, input logic [4:0] wa, input logic [31:0] wd,
                               input logic rdy);
    req_valid = v;
    rs1_addr  = a1;
    rs2_addr  = a2;
    wr_en     = we;
    wr_addr   = wa;
    wr_data   = wd;
    rsp_ready = rdy;
  endtask

  task automatic checkOutput();
    check("req_ready", {31'b0, req_ready}, (exp_q.size() < 2) ? 32'd1 : 32'd0);
    check("rsp_valid", {31'b0, rsp_valid}, (exp_q.size() > 0) ? 32'd1 : 32'd0);
    if (exp_q.size() > 0) begin
      check("rs1_data", rs1_data, exp_q[0][63:32]);
      check("rs2_data", rs2_data, exp_q[0][31:0]);
    end
  endtask

  // One clock: advance the queue model and the external bank, then check
  // outputs on the following falling edge.
  task automatic cycle();
    logic        acc;
    logic [63:0] ent;
    acc = req_valid && (exp_q.size() < 2) && clr_n;
    ent = {ref_read(rs1_addr), ref_read(rs2_addr)};
    @(posedge clk);
    if (exp_q.size() > 0 && rsp_ready) void'(exp_q.pop_front());
    if (acc) exp_q.push_back(ent);
    if (wr_en) begin
      regs[wr_addr] = wr_data;
      update_flat();
    end
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clr_n    = 1'b0;
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1);
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    update_flat();
    @(negedge clk);
    @(negedge clk);
    check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("reset_rs1", rs1_data, 32'h0);
    check("reset_rs2", rs2_data, 32'h0);
    check("reset_req_ready", {31'b0, req_ready}, 32'd1);
    clr_n = 1'b1;

    $display("[TB] basic read");
    regs[3] = 32'hDEADBEEF;
    regs[7] = 32'h12345678;
    update_flat();
    applyStimulus(1'b1, 5'd3, 5'd7, 1'b0, 5'd0, 32'h0, 1'b1);
    cycle();
    check("basic_rs1", rs1_data, 32'hDEADBEEF);
    check("basic_rs2", rs2_data, 32'h12345678);

    $display("[TB] zero register");
    regs[0] = 32'hFFFFFFFF;
    update_flat();
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 32'hAAAA5555, 1'b1);
    cycle();
    check("zero_rs1", rs1_data, 32'h0);
    check("zero_rs2", rs2_data, 32'h0);

    $display("[TB] bypass");
    regs[5] = 32'h11111111;
    regs[6] = 32'h66666666;
    update_flat();
    applyStimulus(1'b1, 5'd5, 5'd6, 1'b1, 5'd5, 32'h22222222, 1'b1);
    cycle();
    check("bypass_rs1", rs1_data, 32'h22222222);
    check("bypass_rs2", rs2_data, 32'h66666666);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1);
    cycle();

    $display("[TB] back-pressure");
    regs[1] = 32'h0000AAAA;
    regs[2] = 32'h0000BBBB;
    update_flat();
    applyStimulus(1'b1, 5'd1, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0);
    cycle();
    applyStimulus(1'b1, 5'd2, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0);
    cycle();
    check("bp_a_held", rs1_data, 32'h0000AAAA);
    check("bp_ready_low", {31'b0, req_ready}, 32'd0);
    applyStimulus(1'b1, 5'd3, 5'd0, 1'b1, 5'd1, 32'hFFFF0001, 1'b0);
    cycle();
    applyStimulus(1'b1, 5'd3, 5'd0, 1'b1, 5'd2, 32'hFFFF0002, 1'b0);
    cycle();
    check("bp_a_snapshot", rs1_data, 32'h0000AAAA);
    applyStimulus(1'b1, 5'd3, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1);
    cycle();
    check("bp_b_out", rs1_data, 32'h0000BBBB);
    check("bp_ready_back", {31'b0, req_ready}, 32'd1);
    cycle();
    check("bp_c_out", rs1_data, 32'hDEADBEEF);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1);
    cycle();

    $display("[TB] reset with skid full");
    applyStimulus(1'b1, 5'd3, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0);
    cycle();
    cycle();
    check("pre_reset_ready", {31'b0, req_ready}, 32'd0);
    clr_n = 1'b0;
    #1;
    exp_q.delete();
    check("async_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("async_rs1", rs1_data, 32'h0);
    check("async_rs2", rs2_data, 32'h0);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1);
    cycle();
    clr_n = 1'b1;
    check("post_reset_ready", {31'b0, req_ready}, 32'd1);
    applyStimulus(1'b1, 5'd7, 5'd3, 1'b0, 5'd0, 32'h0, 1'b1);
    cycle();
    check("post_reset_rs1", rs1_data, 32'h12345678);
    check("post_reset_rs2", rs2_data, 32'hDEADBEEF);

    $display("[TB] streaming");
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b1, 5'(i), 5'(31 - i), 1'b0, 5'd0, 32'h0, 1'b1);
      cycle();
      check("stream_valid", {31'b0, rsp_valid}, 32'd1);
    end
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1);
    cycle();

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      logic [4:0] a1;
      logic [4:0] a2;
      logic [4:0] wa;
      a1 = 5'($urandom);
      a2 = 5'($urandom);
      wa = ($urandom % 2 == 0) ? a1 : 5'($urandom);
      if ($urandom % 8 == 0) begin
        regs[$urandom % 32] = $urandom;
        update_flat();
      end
      applyStimulus(($urandom % 4) != 0, a1, a2, ($urandom % 2) == 1, wa, $urandom,
                    ($urandom % 3) != 0);
      cycle();
    end
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1);
    cycle();
    cycle();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_read_port.md
Name: regfile_read_port

Overview:
Read side of the register file. It accepts dual-source read requests (rs1, rs2) and samples the flattened q outputs of the 32-bit enable/clear register bank. It applies write-to-read bypass for the write landing on the same edge and returns registered read data over a valid/ready response channel. A two-entry output buffer (output register plus skid register) absorbs consumer back-pressure without losing accepted requests.

Parameters:
WIDTH, 32, data width of each register
NREGS, 32, number of registers in the bank
ADDR_W, 5, address width; NREGS == 2**ADDR_W

Ports:
clk  input  1  rising-edge clock
clr_n  input  1  asynchronous active-low reset
req_valid  input  1  read request present
req_ready  output  1  request accepted this cycle when high together with req_valid
rs1_addr  input  ADDR_W  source 1 register index
rs2_addr  input  ADDR_W  source 2 register index
regs_flat  input  NREGS*WIDTH  bank q outputs; register i occupies bits [i*WIDTH +: WIDTH]
wr_en  input  1  bank write enable for the current edge
wr_addr  input  ADDR_W  bank write index
wr_data  input  WIDTH  bank write data
rsp_valid  output  1  response data valid
rsp_ready  input  1  consumer accepts the response
rs1_data  output  WIDTH  source 1 read data
rs2_data  output  WIDTH  source 2 read data

Behaviour:
- Reset (clr_n low, asynchronous, any time): rsp_valid=0, rs1_data=rs2_data=0, skid_valid=0, skid data=0. req_ready=1 whenever clr_n is high and skid is empty. Release is synchronous to the next clk edge. In-flight data is discarded, with no partial response.
- Accept: req_valid && req_ready at a rising edge.
- Read value per source, evaluated combinationally in the accept cycle:
  - addr==0 -> 0, regardless of regs_flat and wr_*.
  - else if wr_en && wr_addr==addr -> wr_data (bypass, because the bank updates on the same edge).
  - else -> regs_flat slice for addr.
- Latency: accepted in cycle N -> data presented with rsp_valid=1 in cycle N+1 if the output stage is free.
- Snapshot semantics: the returned value is the value at the accept edge. Later bank writes never alter a held response.
- Output stage holds when rsp_valid && !rsp_ready. rs1_data, rs2_data and rsp_valid stay stable until the handshake.
- Output stage is free when !rsp_valid || rsp_ready.
- req_ready = !skid_valid. It is a registered-state function only, with no combinational path from rsp_ready.
- Accept with output free: load the output register, rsp_valid=1.
- Accept with output stalled: load the skid register, skid_valid=1, so req_ready drops next cycle.
- skid_valid && rsp_ready: move skid to output (rsp_valid stays 1), skid_valid=0. No accept can coincide because req_ready=0.
- rsp_valid && rsp_ready with no accept and skid empty: rsp_valid=0. Data registers may hold their last value.
- Ordering is strictly FIFO: a skid entry is always older than any later accept.
- Throughput is one request per cycle when rsp_ready is held high.
- No X propagation: addresses are used only on accept. Out-of-range addresses are impossible by parameter constraint.

Test Plan:
- Reset: assert clr_n=0 mid-stream with skid full -> immediately rsp_valid=0, rs1_data=rs2_data=0. After release, req_ready=1 and the first new request returns after 1 cycle.
- Basic read: regs_flat reg3=0xDEADBEEF, reg7=0x12345678; request rs1=3, rs2=7 with rsp_ready=1 -> next cycle rsp_valid=1, rs1_data=0xDEADBEEF, rs2_data=0x12345678.
- Zero register: reg0 slice=0xFFFFFFFF, wr_en=1, wr_addr=0, wr_data=0xAAAA5555; request rs1=0, rs2=0 -> both data 0x00000000.
- Bypass: reg5 slice=0x11111111, wr_en=1, wr_addr=5, wr_data=0x22222222 in the accept cycle; rs1=5, rs2=6 -> rs1_data=0x22222222, rs2_data=reg6 slice.
- Back-pressure: rsp_ready=0, issue requests A (rs1=1) and B (rs1=2) on consecutive cycles -> A held on output, B in skid, req_ready=0, C stalls. Change reg1/reg2 slices meanwhile -> A and B data unchanged. Raise rsp_ready -> A, then B, then C delivered in order, req_ready back to 1 one cycle after B moves.
- Streaming: 32 back-to-back requests rs1=i, rs2=31-i with rsp_ready=1 -> 32 consecutive responses, each 1 cycle after its accept, rsp_valid continuously high.
